nn_fpga_top_mac_acc: RTL



---
 rtl/nn_fpga_mac_pkg.sv | 28 ++
 rtl/nn_fpga_top_sat_narrow.sv | 39 +++
 rtl/nn_fpga_top_mac_acc.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/nn_fpga_mac_pkg.sv
// Shared types and constants for the neuron MAC accumulator and its saturating narrower.
package nn_fpga_mac_pkg;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_BIAS = 2'd1,
    ST_OUT  = 2'd2
  } mac_state_e;

  localparam int OUT_WIDTH_DFLT = 16;

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam longint OUT_MAX = sat_max(OUT_WIDTH_DFLT);
  localparam longint OUT_MIN = sat_min(OUT_WIDTH_DFLT);

  // Smallest signed accumulator that holds N full-scale unsigned products without overflow.
  function automatic int min_acc_width(input int prod_w, input int n);
    return prod_w + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/nn_fpga_top_sat_narrow.sv
// Combinational signed clamp from IN_WIDTH to OUT_WIDTH with a saturation flag.
module nn_fpga_top_sat_narrow
  import nn_fpga_mac_pkg::*;
#(
  parameter int IN_WIDTH  = 21,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  i_data,
  output logic [OUT_WIDTH-1:0] o_data,
  output logic                 o_sat
);

  localparam logic signed [IN_WIDTH-1:0] LIM_MAX = IN_WIDTH'(sat_max(OUT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0] LIM_MIN = IN_WIDTH'(sat_min(OUT_WIDTH));

  if (IN_WIDTH <= OUT_WIDTH) begin : g_bad_width
    $error("nn_fpga_top_sat_narrow: IN_WIDTH must exceed OUT_WIDTH");
  end

  logic signed [IN_WIDTH-1:0] w_in;
  assign w_in = $signed(i_data);

  // Clamp to the representable output range and flag when clamping happened.
  always_comb begin
    o_data = i_data[OUT_WIDTH-1:0];
    o_sat  = 1'b0;
    if (w_in > LIM_MAX) begin
      o_data = LIM_MAX[OUT_WIDTH-1:0];
      o_sat  = 1'b1;
    end else if (w_in < LIM_MIN) begin
      o_data = LIM_MIN[OUT_WIDTH-1:0];
      o_sat  = 1'b1;
    end else begin
      o_data = i_data[OUT_WIDTH-1:0];
      o_sat  = 1'b0;
    end
  end

endmodule

// File: rtl/nn_fpga_top_mac_acc.sv
// Neuron accumulator: sums N_INPUTS products, adds bias, saturates, hands result downstream.
// Optional tlast framing checker enabled by defining NN_FPGA_MAC_TLAST_CHECK_EN.
module nn_fpga_top_mac_acc
  import nn_fpga_mac_pkg::*;
#(
  parameter int PROD_WIDTH = 13,
  parameter int N_INPUTS   = 16,
  parameter int BIAS_WIDTH = 12,
  parameter int ACC_WIDTH  = 20,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [PROD_WIDTH-1:0] prod_tdata,
  input  logic                  prod_tvalid,
  output logic                  prod_tready,
`ifdef NN_FPGA_MAC_TLAST_CHECK_EN
  input  logic                  prod_tlast,
  output logic                  err_frame,
`endif
  input  logic [BIAS_WIDTH-1:0] bias,
  output logic [OUT_WIDTH-1:0]  out_tdata,
  output logic                  out_sat,
  output logic                  out_tvalid,
  input  logic                  out_tready
);

  localparam int CNT_W = (N_INPUTS > 2) ? $clog2(N_INPUTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

  if (ACC_WIDTH < min_acc_width(PROD_WIDTH, N_INPUTS)) begin : g_bad_acc
    $error("nn_fpga_top_mac_acc: ACC_WIDTH too small for PROD_WIDTH and N_INPUTS");
  end

  mac_state_e                  r_state;
  mac_state_e                  w_state_nxt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_prod_tready;
  logic [OUT_WIDTH-1:0]        r_out_tdata;
  logic                        r_out_sat;
  logic                        r_out_tvalid;
  logic                        w_beat;
  logic                        w_last;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH:0]   w_sum;
  logic [OUT_WIDTH-1:0]        w_sat_data;
  logic                        w_sat_flag;

  assign w_beat     = prod_tvalid & r_prod_tready;
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_prod_ext = $signed({{(ACC_WIDTH - PROD_WIDTH){1'b0}}, prod_tdata});
  assign w_sum      = (ACC_WIDTH + 1)'(r_acc) + (ACC_WIDTH + 1)'($signed(bias));

  nn_fpga_top_sat_narrow #(
    .IN_WIDTH  (ACC_WIDTH + 1),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat (
    .i_data (w_sum),
    .o_data (w_sat_data),
    .o_sat  (w_sat_flag)
  );

  // Next-state selection for the accumulate / bias / output cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC: begin
        if (w_beat && w_last) w_state_nxt = ST_BIAS;
        else                  w_state_nxt = ST_ACC;
      end
      ST_BIAS: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (r_out_tvalid && out_tready) w_state_nxt = ST_ACC;
        else                            w_state_nxt = ST_OUT;
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // State, accumulator, counter and registered handshake outputs.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state       <= ST_ACC;
      r_acc         <= '0;
      r_cnt         <= '0;
      r_prod_tready <= 1'b0;
      r_out_tdata   <= '0;
      r_out_sat     <= 1'b0;
      r_out_tvalid  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_prod_tready <= (w_state_nxt == ST_ACC);
      case (r_state)
        ST_ACC: begin
          if (w_beat) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
          end
        end
        ST_BIAS: begin
          r_out_tdata  <= w_sat_data;
          r_out_sat    <= w_sat_flag;
          r_out_tvalid <= 1'b1;
        end
        ST_OUT: begin
          if (r_out_tvalid && out_tready) begin
            r_out_tvalid <= 1'b0;
            r_acc        <= '0;
          end
        end
        default: begin
          r_acc <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

`ifdef NN_FPGA_MAC_TLAST_CHECK_EN
  logic r_err_frame;

  // Sticky flag: tlast disagrees with the count-based frame boundary.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_err_frame <= 1'b0;
    end else if (r_state == ST_ACC && w_beat && (prod_tlast != w_last)) begin
      r_err_frame <= 1'b1;
    end
  end

  assign err_frame = r_err_frame;
`endif

  assign prod_tready = r_prod_tready;
  assign out_tdata   = r_out_tdata;
  assign out_sat     = r_out_sat;
  assign out_tvalid  = r_out_tvalid;

endmodule
